// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, lane geometry
// and the "no write" lane-enable pattern.
package dmem_pkg;

  typedef enum logic {
    S_CPU  = 1'b0,
    S_HOST = 1'b1
  } state_t;

  localparam int unsigned LANES  = 4;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8 * LANES;

  localparam logic [LANES-1:0] WREN_NONE = 4'hF;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned   W     = 8,
  parameter logic [W-1:0]  LIMIT = '1
) (
  input  logic         clk,
  input  logic         rstd,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the byte-lane data memory: CPU-priority with
// host starvation relief, plus a bounded host lock mode for burst transfers.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned MAX_LOCK = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rstd,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [LANES-1:0]  cpu_wren_n,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_lock,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [LANES-1:0]  host_wren_n,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [LANES-1:0]  mem_wren_n,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned LOCK_W = $clog2(MAX_LOCK + 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [LOCK_W-1:0] lock_cnt;
  logic              wait_max;
  logic              lock_max;
  logic              lock_clr;

  assign wait_max = (wait_cnt == WAIT_W'(MAX_WAIT));
  assign lock_max = (lock_cnt == LOCK_W'(MAX_LOCK));

  // Grants are forced low while reset is asserted so nothing reaches the lanes.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    state_d  = state_q;
    if (rstd) begin
      case (state_q)
        S_CPU: begin
          if (host_req && wait_max) begin
            host_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (host_req) begin
            host_gnt = 1'b1;
          end
          if (host_gnt && host_lock) begin
            state_d = S_HOST;
          end
        end
        S_HOST: begin
          if (lock_max && cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (host_req) begin
            host_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
          if (!host_req || !host_lock || lock_max) begin
            state_d = S_CPU;
          end
        end
        default: state_d = S_CPU;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstd) begin
    if (!rstd) begin
      state_q <= S_CPU;
    end else begin
      state_q <= state_d;
    end
  end

  assign cpu_stall = rstd & cpu_req & ~cpu_gnt;
  assign lock_clr  = (state_q == S_CPU) || (state_d == S_CPU);

  sat_counter #(.W(WAIT_W), .LIMIT(WAIT_W'(MAX_WAIT))) u_wait_cnt (
    .clk  (clk),
    .rstd (rstd),
    .inc  (host_req & ~host_gnt),
    .clr  (host_gnt | ~host_req),
    .cnt  (wait_cnt)
  );

  sat_counter #(.W(LOCK_W), .LIMIT(LOCK_W'(MAX_LOCK))) u_lock_cnt (
    .clk  (clk),
    .rstd (rstd),
    .inc  (host_gnt & (state_q == S_HOST)),
    .clr  (lock_clr),
    .cnt  (lock_cnt)
  );

  sat_counter #(.W(CNT_W), .LIMIT({CNT_W{1'b1}})) u_stall_cnt (
    .clk  (clk),
    .rstd (rstd),
    .inc  (cpu_stall),
    .clr  (1'b0),
    .cnt  (stall_cnt)
  );

  always_comb begin
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wren_n = WREN_NONE;
    if (cpu_gnt) begin
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      mem_wren_n = cpu_wren_n;
    end else if (host_gnt) begin
      mem_addr   = host_addr;
      mem_wdata  = host_wdata;
      mem_wren_n = host_wren_n;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural four-lane memory behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstd = 1'b0;
  logic        cpu_req = 1'b0;
  logic [7:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wren_n = 4'hF;
  logic        cpu_gnt, cpu_stall;
  logic [31:0] cpu_rdata;
  logic        host_req = 1'b0;
  logic        host_lock = 1'b0;
  logic [7:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [3:0]  host_wren_n = 4'hF;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wren_n;
  logic [31:0] mem_rdata;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;

  typedef struct {
    logic        cr;
    logic [7:0]  ca;
    logic [31:0] cw;
    logic [3:0]  cwn;
    logic        hr;
    logic        hl;
    logic [7:0]  ha;
    logic [31:0] hw;
    logic [3:0]  hwn;
    logic        eg_c;
    logic        eg_h;
    logic        chk_rd;
    logic [31:0] erd;
  } vec_t;

  dmem_arbiter dut (
    .clk         (clk),
    .rstd        (rstd),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_wren_n  (cpu_wren_n),
    .cpu_gnt     (cpu_gnt),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .host_req    (host_req),
    .host_lock   (host_lock),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_wren_n (host_wren_n),
    .host_gnt    (host_gnt),
    .host_rdata  (host_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wren_n  (mem_wren_n),
    .mem_rdata   (mem_rdata),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Four byte lanes: asynchronous read, write on posedge per active-low enable.
  logic [7:0] lanes [4][256];

  initial begin
    for (int l = 0; l < 4; l++)
      for (int a = 0; a < 256; a++)
        lanes[l][a] = 8'h00;
  end

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (!mem_wren_n[l]) lanes[l][mem_addr] <= mem_wdata[8*l +: 8];
  end

  always_comb begin
    for (int l = 0; l < 4; l++) mem_rdata[8*l +: 8] = lanes[l][mem_addr];
  end

  function automatic vec_t mk(logic cr, logic [7:0] ca, logic [31:0] cw, logic [3:0] cwn,
                              logic hr, logic hl, logic [7:0] ha, logic [31:0] hw,
                              logic [3:0] hwn, logic eg_c, logic eg_h, logic chk_rd,
                              logic [31:0] erd);
    vec_t v;
    v.cr = cr; v.ca = ca; v.cw = cw; v.cwn = cwn;
    v.hr = hr; v.hl = hl; v.ha = ha; v.hw = hw; v.hwn = hwn;
    v.eg_c = eg_c; v.eg_h = eg_h; v.chk_rd = chk_rd; v.erd = erd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [3:0]  exp_wren;
    logic [7:0]  exp_addr;
    @(negedge clk);
    cpu_req = v.cr;  cpu_addr = v.ca;  cpu_wdata = v.cw;  cpu_wren_n = v.cwn;
    host_req = v.hr; host_lock = v.hl; host_addr = v.ha; host_wdata = v.hw; host_wren_n = v.hwn;
    #1;
    exp_wren = v.eg_c ? v.cwn : (v.eg_h ? v.hwn : 4'hF);
    exp_addr = v.eg_c ? v.ca : (v.eg_h ? v.ha : 8'h00);
    checkOutput({tag, " cpu_gnt"}, 32'(cpu_gnt), 32'(v.eg_c));
    checkOutput({tag, " host_gnt"}, 32'(host_gnt), 32'(v.eg_h));
    checkOutput({tag, " cpu_stall"}, 32'(cpu_stall), 32'(v.cr & ~v.eg_c));
    checkOutput({tag, " stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    checkOutput({tag, " mem_wren_n"}, 32'(mem_wren_n), 32'(exp_wren));
    checkOutput({tag, " mem_addr"}, 32'(mem_addr), 32'(exp_addr));
    if (v.chk_rd && v.eg_c) checkOutput({tag, " cpu_rdata"}, cpu_rdata, v.erd);
    if (v.chk_rd && v.eg_h) checkOutput({tag, " host_rdata"}, host_rdata, v.erd);
    if (v.cr && !v.eg_c) exp_stall++;
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = mk(1, 8'h10, 32'hDEADBEEF, 4'h0, 0, 0, 8'h00, 32'h0, 4'hF, 1, 0, 0, 32'h0);
    vecs[1] = mk(1, 8'h10, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 1, 0, 1, 32'hDEADBEEF);
    vecs[2] = mk(1, 8'h20, 32'hAAAAAAAA, 4'h0, 0, 0, 8'h00, 32'h0, 4'hF, 1, 0, 0, 32'h0);
    vecs[3] = mk(1, 8'h20, 32'h11223344, 4'hE, 0, 0, 8'h00, 32'h0, 4'hF, 1, 0, 0, 32'h0);
    vecs[4] = mk(1, 8'h20, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 1, 0, 1, 32'hAAAAAA44);
    vecs[5] = mk(0, 8'h20, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 0, 0, 0, 32'h0);
    vecs[6] = mk(0, 8'h00, 32'h0, 4'hF, 1, 0, 8'h10, 32'h0, 4'hF, 0, 1, 1, 32'hDEADBEEF);
    vecs[7] = mk(0, 8'h00, 32'h0, 4'hF, 1, 0, 8'h30, 32'hCAFEF00D, 4'h0, 0, 1, 0, 32'h0);
    vecs[8] = mk(1, 8'h30, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 1, 0, 1, 32'hCAFEF00D);

    // Reset state while rstd is low, then release away from the clock edge.
    cpu_req = 1'b1;
    host_req = 1'b1;
    #2;
    checkOutput("reset cpu_gnt", 32'(cpu_gnt), 32'h0);
    checkOutput("reset host_gnt", 32'(host_gnt), 32'h0);
    checkOutput("reset cpu_stall", 32'(cpu_stall), 32'h0);
    checkOutput("reset mem_wren_n", 32'(mem_wren_n), 32'hF);
    checkOutput("reset stall_cnt", 32'(stall_cnt), 32'h0);
    cpu_req = 1'b0;
    host_req = 1'b0;
    @(negedge clk);
    rstd = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Continuous contention: four CPU grants then one starvation-relief host grant.
    for (int c = 0; c < 15; c++)
      applyStimulus(mk(1, 8'h10, 32'h0, 4'hF, 1, 0, 8'h20, 32'h0, 4'hF,
                       (c % 5) != 4, (c % 5) == 4, 1, (c % 5) == 4 ? 32'hAAAAAA44 : 32'hDEADBEEF),
                    $sformatf("contend%0d", c));
    applyStimulus(mk(0, 8'h00, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 0, 0, 0, 32'h0), "idle_a");

    // Locked burst: 4 CPU, 17 host (1 forced + 16 locked), then forced CPU release.
    for (int c = 0; c < 22; c++)
      applyStimulus(mk(1, 8'h10, 32'h0, 4'hF, 1, 1, 8'h30, 32'h0, 4'hF,
                       (c < 4) || (c == 21), (c >= 4) && (c < 21), 1,
                       ((c < 4) || (c == 21)) ? 32'hDEADBEEF : 32'hCAFEF00D),
                    $sformatf("burst%0d", c));
    applyStimulus(mk(0, 8'h00, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 0, 0, 0, 32'h0), "idle_b");

    // Lock dropped after three locked grants: host keeps that cycle, CPU next.
    for (int c = 0; c < 9; c++)
      applyStimulus(mk(1, 8'h10, 32'h0, 4'hF, 1, (c != 7), 8'h30, 32'h0, 4'hF,
                       (c < 4) || (c == 8), (c >= 4) && (c < 8), 0, 32'h0),
                    $sformatf("release%0d", c));
    applyStimulus(mk(0, 8'h00, 32'h0, 4'hF, 0, 0, 8'h00, 32'h0, 4'hF, 0, 0, 0, 32'h0), "idle_c");

    // Enter S_HOST, then assert reset during a pending host write.
    applyStimulus(mk(0, 8'h00, 32'h0, 4'hF, 1, 1, 8'h10, 32'h0, 4'hF, 0, 1, 1, 32'hDEADBEEF), "lock_in");
    applyStimulus(mk(1, 8'h50, 32'h0, 4'hF, 1, 1, 8'h10, 32'h12345678, 4'h0, 0, 1, 0, 32'h0), "pend_wr");
    #1;
    rstd = 1'b0;
    #1;
    exp_stall = 0;
    checkOutput("midrst cpu_gnt", 32'(cpu_gnt), 32'h0);
    checkOutput("midrst host_gnt", 32'(host_gnt), 32'h0);
    checkOutput("midrst mem_wren_n", 32'(mem_wren_n), 32'hF);
    checkOutput("midrst cpu_stall", 32'(cpu_stall), 32'h0);
    checkOutput("midrst stall_cnt", 32'(stall_cnt), 32'h0);
    @(posedge clk);
    #2;
    checkOutput("midrst word", {lanes[3][8'h10], lanes[2][8'h10], lanes[1][8'h10], lanes[0][8'h10]},
                32'hDEADBEEF);
    cpu_req = 1'b0;
    host_req = 1'b0;
    host_lock = 1'b0;
    host_wren_n = 4'hF;
    @(negedge clk);
    rstd = 1'b1;
    applyStimulus(mk(1, 8'h10, 32'h0, 4'hF, 1, 1, 8'h30, 32'h0, 4'hF, 1, 0, 1, 32'hDEADBEEF), "post_rst");
    applyStimulus(mk(1, 8'h10, 32'h0, 4'hF, 1, 1, 8'h30, 32'h0, 4'hF, 1, 0, 1, 32'hDEADBEEF), "post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
